// File: rtl/sample_tick_sequencer.sv
// Programmable sample-rate scheduler: divides clk_i by a divisor latched at start and
// issues one req/ack sample request per period. Optional macro: SAMPLE_LIMIT_EN (auto-stop).
module sample_tick_sequencer #(
    parameter int DIV_W   = 16,
    parameter int COUNT_W = 24
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               stop_i,
    input  logic [DIV_W-1:0]   rate_div_i,
    input  logic               sample_ack_i,
`ifdef SAMPLE_LIMIT_EN
    input  logic [COUNT_W-1:0] sample_limit_i,
`endif
    output logic               sample_req_o,
    output logic               busy_o,
    output logic [COUNT_W-1:0] sample_count_o,
    output logic               overrun_o,
    output logic               done_o
);

    // state | meaning
    // IDLE  | not sequencing; count/overrun hold their last values
    // RUN   | period counter free-running, ticks raise sample requests
    // DRAIN | stop requested with a request outstanding; waiting for its ack
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   cnt_q, cnt_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic               req_q, req_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               ovr_q, ovr_d;
    logic               done_q, done_d;
    logic               tick;
    logic               ack_ok;
    logic               limit_hit;
    logic [COUNT_W-1:0] count_inc;

`ifdef SAMPLE_LIMIT_EN
    logic [COUNT_W-1:0] limit_q, limit_d;
`endif

    assign tick      = (state_q == ST_RUN) && (cnt_q == div_q - DIV_W'(1));
    assign ack_ok    = req_q && sample_ack_i;
    assign count_inc = count_q + COUNT_W'(1);

`ifdef SAMPLE_LIMIT_EN
    assign limit_hit = (limit_q != '0) && (count_inc == limit_q);
`else
    assign limit_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        req_d   = req_q;
        count_d = count_q;
        ovr_d   = ovr_q;
        done_d  = 1'b0;
`ifdef SAMPLE_LIMIT_EN
        limit_d = limit_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start_i && !stop_i) begin
                    state_d = ST_RUN;
                    div_d   = (rate_div_i < DIV_W'(2)) ? DIV_W'(2) : rate_div_i;
                    cnt_d   = '0;
                    count_d = '0;
                    ovr_d   = 1'b0;
`ifdef SAMPLE_LIMIT_EN
                    limit_d = sample_limit_i;
`endif
                end
            end
            ST_RUN: begin
                cnt_d = tick ? '0 : cnt_q + DIV_W'(1);
                if (ack_ok) begin
                    count_d = count_inc;
                    if (limit_hit) begin
                        // auto-stop: a coinciding tick is dropped
                        req_d   = 1'b0;
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        req_d = tick;
                    end
                end else if (tick) begin
                    if (req_q) ovr_d = 1'b1;
                    else       req_d = 1'b1;
                end
                if (stop_i && !(ack_ok && limit_hit)) begin
                    state_d = req_d ? ST_DRAIN : ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (ack_ok) begin
                    count_d = count_inc;
                    req_d   = 1'b0;
                    state_d = ST_IDLE;
                    done_d  = limit_hit;
                end
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            div_q   <= DIV_W'(2);
            req_q   <= 1'b0;
            count_q <= '0;
            ovr_q   <= 1'b0;
            done_q  <= 1'b0;
`ifdef SAMPLE_LIMIT_EN
            limit_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            req_q   <= req_d;
            count_q <= count_d;
            ovr_q   <= ovr_d;
            done_q  <= done_d;
`ifdef SAMPLE_LIMIT_EN
            limit_q <= limit_d;
`endif
        end
    end

    assign sample_req_o   = req_q;
    assign busy_o         = (state_q != ST_IDLE);
    assign sample_count_o = count_q;
    assign overrun_o      = ovr_q;
    assign done_o         = done_q;

endmodule

// File: tb/tb_sample_tick_sequencer.sv
// Scoreboard bench for sample_tick_sequencer: a behavioural model predicts the outputs
// after every edge, a monitor compares them against the DUT.
module tb_sample_tick_sequencer;

    localparam int DIV_W   = 16;
    localparam int COUNT_W = 24;

    logic               clk = 1'b0;
    logic               rst, start, stop, ack;
    logic [DIV_W-1:0]   rate_div;
    logic               req, busy, ovr, done;
    logic [COUNT_W-1:0] count;
    logic [COUNT_W-1:0] limit;

    sample_tick_sequencer #(.DIV_W(DIV_W), .COUNT_W(COUNT_W)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .start_i        (start),
        .stop_i         (stop),
        .rate_div_i     (rate_div),
        .sample_ack_i   (ack),
`ifdef SAMPLE_LIMIT_EN
        .sample_limit_i (limit),
`endif
        .sample_req_o   (req),
        .busy_o         (busy),
        .sample_count_o (count),
        .overrun_o      (ovr),
        .done_o         (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                 tag;
        logic               req;
        logic               busy;
        logic [COUNT_W-1:0] count;
        logic               ovr;
        logic               done;
    } exp_t;

    exp_t exp_q[$];
    int   edge_n   = 0;
    int   checks   = 0;
    int   failures = 0;

    // reference model: mode 0 idle, 1 running, 2 draining; ticks are every div-th edge since start
    int                 m_mode = 0;
    int                 m_div  = 2;
    int                 m_t    = 0;
    bit                 m_pend = 0;
    bit                 m_ovr  = 0;
    bit                 m_done = 0;
    logic [COUNT_W-1:0] m_cnt  = '0;
    logic [COUNT_W-1:0] m_lim  = '0;

    function automatic bit lim_reached();
`ifdef SAMPLE_LIMIT_EN
        return (m_lim != 0) && (m_cnt == m_lim);
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_edge(input bit r, input bit st, input bit sp, input bit ak,
                              input logic [DIV_W-1:0] rd, input logic [COUNT_W-1:0] lim);
        bit tk;
        m_done = 0;
        if (r) begin
            m_mode = 0; m_pend = 0; m_cnt = '0; m_ovr = 0; m_div = 2; m_t = 0; m_lim = '0;
        end else if (m_mode == 0) begin
            if (st && !sp) begin
                m_mode = 1;
                m_div  = (int'(rd) < 2) ? 2 : int'(rd);
                m_t    = 0;
                m_cnt  = '0;
                m_ovr  = 0;
                m_lim  = lim;
            end
        end else if (m_mode == 1) begin
            m_t++;
            tk = (m_t % m_div) == 0;
            if (m_pend && ak) begin
                m_cnt++;
                if (lim_reached()) begin
                    m_pend = 0; m_mode = 0; m_done = 1;
                end else begin
                    m_pend = tk;
                end
            end else if (tk) begin
                if (m_pend) m_ovr = 1;
                else        m_pend = 1;
            end
            if (m_mode == 1 && sp) m_mode = m_pend ? 2 : 0;
        end else begin
            if (m_pend && ak) begin
                m_cnt++;
                m_pend = 0;
                m_mode = 0;
                m_done = lim_reached();
            end
        end
    endtask

    // called at posedge+1: drives inputs for the next edge and queues the predicted outputs
    task automatic step(input bit r, input bit st, input bit sp, input bit ak,
                        input logic [DIV_W-1:0] rd);
        exp_t e;
        rst = r; start = st; stop = sp; ack = ak; rate_div = rd;
        model_edge(r, st, sp, ak, rd, limit);
        e.tag   = edge_n + 1;
        e.req   = m_pend;
        e.busy  = (m_mode != 0);
        e.count = m_cnt;
        e.ovr   = m_ovr;
        e.done  = m_done;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // ack policy: 0 random, 1 answer the visible request, 2 withhold, 3 always high
    function automatic bit pick_ack(input int mode);
        case (mode)
            0:       return 1'($urandom_range(0, 1));
            1:       return req;
            2:       return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            edge_n++;
            #2;
            if (exp_q.size() != 0 && exp_q[0].tag == edge_n) begin
                e = exp_q.pop_front();
                checks++;
                if (req !== e.req || busy !== e.busy || count !== e.count ||
                    ovr !== e.ovr || done !== e.done) begin
                    failures++;
                    $display("FAIL outputs edge=%0d got req=%0b busy=%0b count=%0d ovr=%0b done=%0b expected req=%0b busy=%0b count=%0d ovr=%0b done=%0b",
                             edge_n, req, busy, count, ovr, done,
                             e.req, e.busy, e.count, e.ovr, e.done);
                end
            end
        end
    end

    task automatic drain(input logic [DIV_W-1:0] rd);
        for (int i = 0; i < 64 && m_mode != 0; i++) step(0, 0, 1, 1, rd);
    endtask

    task automatic episode(input logic [DIV_W-1:0] rd, input int ack_mode, input int len,
                           input bit noise);
        logic [DIV_W-1:0] rd_run;
        step(0, 1, 0, 0, rd);
        for (int i = 0; i < len && m_mode != 0; i++) begin
            rd_run = noise ? DIV_W'($urandom_range(0, 9)) : rd;
            step(0, noise & 1'($urandom_range(0, 1)), 0, pick_ack(ack_mode), rd_run);
        end
        if (m_mode != 0) step(0, 0, 1, pick_ack(ack_mode), rd);
        drain(rd);
        step(0, 0, 0, 0, rd);
    endtask

    initial begin : stimulus
        rst = 1'b1; start = 1'b0; stop = 1'b0; ack = 1'b0; rate_div = '0; limit = '0;
        @(posedge clk);
        #1;
        step(1, 0, 0, 0, 0);
        step(1, 1, 0, 1, 4);
        step(0, 0, 0, 0, 4);

        // period 4, ack answered as soon as the request is visible
        episode(4, 1, 22, 0);
        // divisors below 2 clamp to 2
        episode(0, 1, 10, 0);
        episode(1, 1, 10, 0);
        // period 5, ack withheld long enough for an overrun, then answered
        step(0, 1, 0, 0, 5);
        for (int i = 0; i < 12; i++) step(0, 0, 0, 0, 5);
        for (int i = 0; i < 12; i++) step(0, 0, 0, pick_ack(1), 5);
        step(0, 0, 1, 0, 5);
        drain(5);
        // ack lands exactly on a tick edge
        step(0, 1, 0, 0, 3);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 3);
        step(0, 0, 0, 1, 3);
        step(0, 0, 0, 0, 3);
        step(0, 0, 1, 0, 3);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 3);
        drain(3);
        // start together with stop in idle stays idle
        step(0, 1, 1, 0, 4);
        step(0, 1, 1, 1, 4);
        // mid-run reset, late ack afterwards
        step(0, 1, 0, 0, 2);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 2);
        step(1, 0, 0, 1, 2);
        step(0, 0, 0, 1, 2);
        step(0, 0, 0, 0, 2);
`ifdef SAMPLE_LIMIT_EN
        limit = 3;
        episode(4, 1, 40, 0);
        limit = 2;
        episode(3, 3, 40, 0);
        limit = 0;
`endif

        for (int ep = 0; ep < 40; ep++) begin
`ifdef SAMPLE_LIMIT_EN
            limit = COUNT_W'($urandom_range(0, 4));
`endif
            if ($urandom_range(0, 7) == 0) step(1, 0, 0, 0, 0);
            if ($urandom_range(0, 5) == 0) step(0, 1, 1, 1, 3);
            episode(DIV_W'($urandom_range(0, 9)), $urandom_range(0, 3),
                    $urandom_range(5, 60), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 4) == 0) begin
                step(0, 1, 0, 0, 3);
                for (int i = 0; i < 4; i++) step(0, 0, 0, pick_ack(0), 3);
                step(1, 0, 0, 1, 3);
            end
        end

        step(0, 0, 0, 0, 2);
        @(posedge clk);
        #3;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain left=%0d expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
